// File: rtl/instr_fetch.sv
// instr_fetch: fetch/sequencing stage in front of a 256x8 instruction RAM.
// Reads an opcode plus 0/1/2 operand bytes, presents the assembled instruction
// on a valid/ready handshake, resolves jpnz at handshake time, and halts on
// endop or an illegal opcode.
// Optional build macro: INSTR_FETCH_COUNT_EN adds a saturating 16-bit
// retired-instruction counter on output retired_count.
module instr_fetch #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0,
  parameter int OP_LDAC  = 4,
  parameter int OP_JPNZ  = 42,
  parameter int OP_ENDOP = 46
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                iram_read,
  output logic [ADDR_W-1:0]   iram_addr,
  input  logic [DATA_W-1:0]   iram_data,
  output logic                instr_valid,
  input  logic                instr_ready,
  output logic [DATA_W-1:0]   instr_opcode,
  output logic [2*DATA_W-1:0] instr_operand,
  input  logic                acc_nz,
  output logic [ADDR_W-1:0]   pc,
  output logic                busy,
  output logic                halted,
`ifdef INSTR_FETCH_COUNT_EN
  output logic [15:0]         retired_count,
`endif
  output logic                illegal
);

  typedef enum logic [3:0] {
    S_IDLE, S_OP_RD, S_OP_CAP, S_R1_RD, S_R1_CAP,
    S_R2_RD, S_R2_CAP, S_ISSUE, S_HALT
  } state_t;

  localparam logic [DATA_W-1:0] LDAC_C  = DATA_W'(OP_LDAC);
  localparam logic [DATA_W-1:0] JPNZ_C  = DATA_W'(OP_JPNZ);
  localparam logic [DATA_W-1:0] ENDOP_C = DATA_W'(OP_ENDOP);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     pc_q, pc_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  rd_q, rd_d;
  logic                  vld_q, vld_d;
  logic [DATA_W-1:0]     opcode_q, opcode_d;
  logic [2*DATA_W-1:0]   operand_q, operand_d;
  logic                  halted_q, halted_d;
  logic                  illegal_q, illegal_d;
  logic                  busy_q, busy_d;
  logic                  start_ok;
  logic                  handshake;

  // Opcode map: 0, 4, 8, 11, 19..42, 46 are decodable; everything else traps.
  function automatic logic is_legal(input logic [DATA_W-1:0] op);
    is_legal = (op == DATA_W'(0))  || (op == DATA_W'(4)) ||
               (op == DATA_W'(8))  || (op == DATA_W'(11)) ||
               ((op >= DATA_W'(19)) && (op <= DATA_W'(42))) ||
               (op == DATA_W'(46));
  endfunction

  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign handshake = vld_q && instr_ready;

  // Next-state, PC and instruction assembly; outputs are derived from the
  // next state so every port comes straight off a flop.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    opcode_d  = opcode_q;
    operand_d = operand_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d      = RST_PC;
          illegal_d = 1'b0;
          state_d   = S_OP_RD;
        end
      end
      S_OP_RD: state_d = S_OP_CAP;
      S_R1_RD: state_d = S_R1_CAP;
      S_R2_RD: state_d = S_R2_CAP;
      S_OP_CAP: begin
        pc_d      = pc_q + 1'b1;
        opcode_d  = iram_data;
        operand_d = '0;
        if (!is_legal(iram_data)) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if ((iram_data == LDAC_C) || (iram_data == JPNZ_C)) begin
          state_d = S_R1_RD;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_R1_CAP: begin
        pc_d                 = pc_q + 1'b1;
        operand_d[DATA_W-1:0] = iram_data;
        state_d              = (opcode_q == LDAC_C) ? S_R2_RD : S_ISSUE;
      end
      S_R2_CAP: begin
        pc_d                          = pc_q + 1'b1;
        operand_d[2*DATA_W-1:DATA_W]  = iram_data;
        state_d                       = S_ISSUE;
      end
      S_ISSUE: begin
        if (handshake) begin
          if (opcode_q == ENDOP_C) begin
            state_d = S_HALT;
          end else begin
            // Taken jpnz redirects; not-taken simply continues at pc.
            if ((opcode_q == JPNZ_C) && acc_nz)
              pc_d = operand_q[ADDR_W-1:0];
            state_d = S_OP_RD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Registered output decode from the next state.
  always_comb begin
    rd_d     = (state_d == S_OP_RD) || (state_d == S_R1_RD) || (state_d == S_R2_RD);
    addr_d   = rd_d ? pc_d : addr_q;
    vld_d    = (state_d == S_ISSUE);
    halted_d = (state_d == S_HALT);
    busy_d   = (state_d != S_IDLE) && (state_d != S_HALT);
  end

  // State and output flops; reset drops any in-flight fetch or issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= RST_PC;
      addr_q    <= '0;
      rd_q      <= 1'b0;
      vld_q     <= 1'b0;
      opcode_q  <= '0;
      operand_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      rd_q      <= rd_d;
      vld_q     <= vld_d;
      opcode_q  <= opcode_d;
      operand_q <= operand_d;
      halted_q  <= halted_d;
      illegal_q <= illegal_d;
      busy_q    <= busy_d;
    end
  end

  assign iram_read     = rd_q;
  assign iram_addr     = addr_q;
  assign instr_valid   = vld_q;
  assign instr_opcode  = opcode_q;
  assign instr_operand = operand_q;
  assign pc            = pc_q;
  assign busy          = busy_q;
  assign halted        = halted_q;
  assign illegal       = illegal_q;

`ifdef INSTR_FETCH_COUNT_EN
  logic [15:0] cnt_q, cnt_d;

  // Retired count: cleared on accepted start, saturating increment per handshake.
  always_comb begin
    cnt_d = cnt_q;
    if (start_ok)
      cnt_d = '0;
    else if (handshake && (cnt_q != 16'hFFFF))
      cnt_d = cnt_q + 16'd1;
  end

  // Counter flop.
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign retired_count = cnt_q;
`else
  logic unused_start_ok;
  assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: a registered-read RAM model, expected
// instructions queued when each program is loaded, checked at handshake.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst, start, instr_ready, acc_sel;
  logic        iram_read, instr_valid, busy, halted, illegal;
  logic [7:0]  iram_addr, iram_data, instr_opcode, pc;
  logic [15:0] instr_operand;
  logic        acc_nz;
`ifdef INSTR_FETCH_COUNT_EN
  logic [15:0] retired_count;
`endif

  typedef struct packed { logic [7:0] op; logic [15:0] opr; } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  rd_log[$];
  logic [7:0]  mem [256];
  int          checks = 0, failures = 0;
  int          rd_cnt = 0, hs_cnt = 0, vld_cnt = 0;

  always #5 clk = ~clk;

  // jpnz to 47 is always taken; other branches follow acc_sel.
  assign acc_nz = (instr_operand[7:0] == 8'd47) | acc_sel;

  instr_fetch dut (
    .clk(clk), .rst(rst), .start(start),
    .iram_read(iram_read), .iram_addr(iram_addr), .iram_data(iram_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_opcode(instr_opcode), .instr_operand(instr_operand),
    .acc_nz(acc_nz), .pc(pc), .busy(busy), .halted(halted),
`ifdef INSTR_FETCH_COUNT_EN
    .retired_count(retired_count),
`endif
    .illegal(illegal)
  );

  // RAM model: data valid the cycle after the read strobe.
  always @(posedge clk) if (iram_read) iram_data <= mem[iram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: reads, valid cycles and handshakes against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (iram_read) begin rd_cnt++; rd_log.push_back(iram_addr); end
      if (instr_valid) vld_cnt++;
      if (instr_valid && instr_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) chk("sb_unexpected", {24'd0, instr_opcode}, 32'hFFFF_FFFF);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("opcode", {24'd0, instr_opcode}, {24'd0, e.op});
          chk("operand", {16'd0, instr_operand}, {16'd0, e.opr});
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic push(input logic [7:0] op, input logic [15:0] opr);
    exp_t e;
    e.op = op; e.opr = opr;
    exp_q.push_back(e);
  endtask

  task automatic do_start();
    rd_log.delete();
    start = 1'b1; step(1); start = 1'b0;
  endtask

  task automatic wait_halt(input string tag);
    int n = 0;
    while (!halted && n < 200) begin step(1); n++; end
    chk(tag, {31'd0, halted}, 32'd1);
    chk({tag, "_sb_drain"}, exp_q.size(), 0);
  endtask

  initial begin
    int r0, h0, v0, n;
    logic [7:0] op_s;
    logic [15:0] opr_s;
    for (int i = 0; i < 256; i++) mem[i] = 8'd46;
    rst = 1'b1; start = 1'b0; instr_ready = 1'b1; acc_sel = 1'b0;
    step(2);
    rst = 1'b0;
    chk("rst_read", {31'd0, iram_read}, 0);
    chk("rst_addr", {24'd0, iram_addr}, 0);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_pc", {24'd0, pc}, 0);
    chk("rst_flags", {29'd0, busy, halted, illegal}, 0);
    chk("rst_instr", {instr_opcode, instr_operand}, 0);

    // clac; endop
    mem[0] = 8'd19; mem[1] = 8'd46;
    push(8'd19, 16'h0); push(8'd46, 16'h0);
    r0 = rd_cnt; h0 = hs_cnt;
    do_start();
    chk("t1_busy", {31'd0, busy}, 1);
    wait_halt("t1_halt");
    chk("t1_pc", {24'd0, pc}, 2);
    chk("t1_reads", rd_cnt - r0, 2);
    chk("t1_hs", hs_cnt - h0, 2);
`ifdef INSTR_FETCH_COUNT_EN
    chk("t1_retired", {16'd0, retired_count}, 2);
`endif

    // ldac 0x0002 then endop; check issue latency
    mem[0] = 8'd4; mem[1] = 8'd2; mem[2] = 8'd0; mem[3] = 8'd46;
    push(8'd4, 16'h0002); push(8'd46, 16'h0);
    do_start();
    for (int k = 1; k <= 5; k++) begin
      step(1);
      chk("t2_valid_early", {31'd0, instr_valid}, 0);
    end
    step(1);
    chk("t2_valid_7th", {31'd0, instr_valid}, 1);
    chk("t2_pc", {24'd0, pc}, 3);
    wait_halt("t2_halt");

    // jpnz chain: 0 -> 47 (always taken), then jpnz 26 at 47
    mem[0] = 8'd42; mem[1] = 8'd47; mem[47] = 8'd42; mem[48] = 8'd26;
    mem[26] = 8'd46; mem[49] = 8'd46;
    for (int t = 0; t < 2; t++) begin
      acc_sel = (t == 0);
      push(8'd42, 16'd47); push(8'd42, 16'd26); push(8'd46, 16'h0);
      do_start();
      wait_halt("t3_halt");
      chk("t3_nread", rd_log.size(), 5);
      if (rd_log.size() >= 5)
        chk("t3_branch_addr", {24'd0, rd_log[4]}, (t == 0) ? 32'd26 : 32'd49);
      chk("t3_pc", {24'd0, pc}, (t == 0) ? 32'd27 : 32'd50);
    end
    acc_sel = 1'b0;

    // ready stall on opcode 21
    mem[0] = 8'd21; mem[1] = 8'd46;
    push(8'd21, 16'h0); push(8'd46, 16'h0);
    instr_ready = 1'b0;
    h0 = hs_cnt;
    do_start();
    n = 0;
    while (!instr_valid && n < 50) begin step(1); n++; end
    chk("t4_valid_seen", {31'd0, instr_valid}, 1);
    r0 = rd_cnt; op_s = instr_opcode; opr_s = instr_operand;
    for (int k = 0; k < 5; k++) begin
      step(1);
      chk("t4_stall_valid", {31'd0, instr_valid}, 1);
      chk("t4_stall_instr", {instr_opcode, instr_operand}, {op_s, opr_s});
      chk("t4_stall_reads", rd_cnt - r0, 0);
    end
    chk("t4_hs_none", hs_cnt - h0, 0);
    instr_ready = 1'b1;
    wait_halt("t4_halt");
    chk("t4_hs", hs_cnt - h0, 2);

    // illegal opcode 50, then restart clears illegal
    mem[0] = 8'd50;
    v0 = vld_cnt;
    do_start();
    wait_halt("t5_halt");
    chk("t5_illegal", {31'd0, illegal}, 1);
    chk("t5_no_valid", vld_cnt - v0, 0);
    mem[0] = 8'd19; mem[1] = 8'd46;
    push(8'd19, 16'h0); push(8'd46, 16'h0);
    do_start();
    chk("t5_illegal_clr", {31'd0, illegal}, 0);
    chk("t5_refetch", {23'd0, iram_read, iram_addr}, {23'd0, 1'b1, 8'd0});
    wait_halt("t5_rerun");

    // reset during R1_CAP of an ldac
    mem[0] = 8'd4; mem[1] = 8'd1; mem[2] = 8'd2; mem[3] = 8'd46;
    do_start();
    step(3);
    rst = 1'b1; step(1); rst = 1'b0;
    chk("t6_rst_outs", {iram_read, iram_addr, instr_valid, instr_opcode, busy, halted, illegal},
        0);
    chk("t6_rst_pc_opr", {8'd0, pc, instr_operand}, 0);

    // start while busy is ignored
    mem[0] = 8'd19; mem[1] = 8'd46;
    push(8'd19, 16'h0); push(8'd46, 16'h0);
    r0 = rd_cnt; h0 = hs_cnt;
    do_start();
    start = 1'b1; step(2); start = 1'b0;
    wait_halt("t7_halt");
    chk("t7_reads", rd_cnt - r0, 2);
    chk("t7_hs", hs_cnt - h0, 2);

    // pc wrap: jpnz to FE, ldac operands from FF and 00, then opcode at 01 (0xFE illegal)
    mem[0] = 8'd42; mem[1] = 8'hFE; mem[8'hFE] = 8'd4; mem[8'hFF] = 8'h11;
    acc_sel = 1'b1;
    push(8'd42, 16'h00FE); push(8'd4, 16'h2A11);
    do_start();
    wait_halt("t8_halt");
    chk("t8_nread", rd_log.size(), 6);
    if (rd_log.size() >= 6)
      chk("t8_wrap_addrs", {8'd0, rd_log[3], rd_log[4], rd_log[5]}, 32'h00FF_0001);
    chk("t8_illegal", {31'd0, illegal}, 1);
    chk("t8_pc", {24'd0, pc}, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
